// File: rtl/alu_exec_seq_if.sv
// Bus between the register file and the multi-cycle execute stage.
// Handshake: start is sampled only while busy is low; wr_en is a single-cycle
// write-back strobe with no back-pressure, and wr_addr/dat_in/flag are valid only while it is high.
interface alu_exec_seq_if #(
  parameter int AW = 5
);
  logic          start;
  logic [2:0]    op;
  logic [7:0]    opnd;
  logic [7:0]    acc;
  logic [AW-1:0] dst;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    dat_in;
  logic          flag;
  logic [1:0]    state_dbg;

  modport master (
    output start, op, opnd, acc, dst,
    input  busy, wr_en, wr_addr, dat_in, flag, state_dbg
  );

  modport slave (
    input  start, op, opnd, acc, dst,
    output busy, wr_en, wr_addr, dat_in, flag, state_dbg
  );
endinterface

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute stage: latches operands on start, iterates shifts/multiply
// in RUN, then issues exactly one write-back beat in WB.
module alu_exec_seq #(
  parameter int AW = 5
) (
  input logic         clk,
  input logic         rst_n,
  alu_exec_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  state_t        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [7:0]    res_q;
  logic          flag_q;
  logic [3:0]    cnt_q;
  logic [15:0]   mcand_q;
  logic [15:0]   prod_q;
  logic [7:0]    mplier_q;

  logic          accept;
  logic          is_shift;
  logic [3:0]    shamt;
  logic          last;
  logic [8:0]    sum;
  logic [7:0]    alu_res;
  logic          alu_flag;
  logic [15:0]   prod_next;

  assign accept    = (state_q == IDLE) && bus.start;
  assign is_shift  = (bus.op == OP_SHL) || (bus.op == OP_SHR);
  assign shamt     = {1'b0, bus.opnd[2:0]};
  assign last      = (cnt_q == 4'd1);
  assign sum       = {1'b0, bus.acc} + {1'b0, bus.opnd};
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : 16'd0);

  // Single-cycle results are computed from the live inputs at the accept edge;
  // for shifts this is the starting value (and the final one for count 0).
  always_comb begin
    alu_res  = 8'd0;
    alu_flag = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res  = sum[7:0];
        alu_flag = sum[8];
      end
      OP_SUB: begin
        alu_res  = bus.acc - bus.opnd;
        alu_flag = bus.acc < bus.opnd;
      end
      OP_AND: begin
        alu_res  = bus.acc & bus.opnd;
        alu_flag = (bus.acc & bus.opnd) == 8'd0;
      end
      OP_XOR: begin
        alu_res  = bus.acc ^ bus.opnd;
        alu_flag = (bus.acc ^ bus.opnd) == 8'd0;
      end
      OP_SHL, OP_SHR: alu_res = bus.acc;
      OP_MOV: begin
        alu_res  = bus.opnd;
        alu_flag = bus.opnd == 8'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if ((bus.op == OP_MUL) || (is_shift && (shamt != 4'd0))) state_d = RUN;
        else                                                     state_d = WB;
      end
      RUN:     if (last) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      dst_q    <= '0;
      res_q    <= 8'd0;
      flag_q   <= 1'b0;
      cnt_q    <= 4'd0;
      mcand_q  <= 16'd0;
      prod_q   <= 16'd0;
      mplier_q <= 8'd0;
    end else if (accept) begin
      op_q     <= bus.op;
      dst_q    <= bus.dst;
      res_q    <= alu_res;
      flag_q   <= alu_flag;
      cnt_q    <= (bus.op == OP_MUL) ? 4'd8 : shamt;
      mcand_q  <= {8'd0, bus.acc};
      prod_q   <= 16'd0;
      mplier_q <= bus.opnd;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 4'd1;
      if (op_q == OP_MUL) begin
        prod_q   <= prod_next;
        mcand_q  <= {mcand_q[14:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[7:1]};
        if (last) begin
          res_q  <= prod_next[7:0];
          flag_q <= |prod_next[15:8];
        end
      end else if (op_q == OP_SHL) begin
        res_q  <= {res_q[6:0], 1'b0};
        flag_q <= res_q[7];
      end else begin
        res_q  <= {1'b0, res_q[7:1]};
        flag_q <= res_q[0];
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.wr_en     = (state_q == WB);
  assign bus.wr_addr   = dst_q;
  assign bus.dat_in    = res_q;
  assign bus.flag      = flag_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: hand-computed results, write-back edge
// position, single-write accounting and asynchronous reset behaviour.
module tb_alu_exec_seq;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   wr_count = 0;

  always #5 clk = ~clk;

  alu_exec_seq_if #(.AW(AW)) bus ();

  alu_exec_seq #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always @(negedge clk) if (bus.wr_en) wr_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.op   = 3'($urandom);
    bus.acc  = 8'($urandom);
    bus.opnd = 8'($urandom);
    bus.dst  = AW'($urandom);
  endtask

  // ee: index of the edge (accept = 0) at which wr_en rises.
  // spam keeps start high with junk operands until the edge that leaves WB.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [AW-1:0] d, input logic [7:0] er,
                        input logic ef, input int ee, input bit spam);
    int n;
    int w0;
    bus.op    = op;
    bus.acc   = a;
    bus.opnd  = b;
    bus.dst   = d;
    bus.start = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1;
    bus.start = spam;
    scramble();
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.wr_en && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (spam) scramble();
    end
    check({name, "_wb_edge"}, n, ee);
    check({name, "_dat"}, 32'(bus.dat_in), 32'(er));
    check({name, "_flag"}, 32'(bus.flag), 32'(ef));
    check({name, "_addr"}, 32'(bus.wr_addr), 32'(d));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({name, "_wr_drop"}, 32'(bus.wr_en), 32'd0);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
    check({name, "_writes"}, wr_count - w0, 1);
  endtask

  initial begin
    int w0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.acc   = 8'd0;
    bus.opnd  = 8'd0;
    bus.dst   = '0;

    // Reset state
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_dat", 32'(bus.dat_in), 32'd0);
    check("rst_flag", 32'(bus.flag), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",     3'b000, 8'hF0, 8'h20, 5'd3,  8'h10, 1'b1, 0, 1'b0);
    run_op("sub",     3'b001, 8'h05, 8'h07, 5'd4,  8'hFE, 1'b1, 0, 1'b0);
    run_op("sub_nb",  3'b001, 8'h07, 8'h05, 5'd5,  8'h02, 1'b0, 0, 1'b0);
    run_op("add_nc",  3'b000, 8'h7F, 8'h01, 5'd6,  8'h80, 1'b0, 0, 1'b0);
    run_op("shl3",    3'b100, 8'h81, 8'h03, 5'd7,  8'h08, 1'b0, 3, 1'b0);
    run_op("shr1",    3'b101, 8'h81, 8'h01, 5'd8,  8'h40, 1'b1, 1, 1'b0);
    run_op("shl0",    3'b100, 8'h81, 8'h08, 5'd9,  8'h81, 1'b0, 0, 1'b0);
    run_op("shl7",    3'b100, 8'hFF, 8'hFF, 5'd10, 8'h80, 1'b1, 7, 1'b0);
    run_op("shr7",    3'b101, 8'h80, 8'h07, 5'd11, 8'h01, 1'b0, 7, 1'b0);
    run_op("mul_a",   3'b110, 8'h10, 8'h11, 5'd12, 8'h10, 1'b1, 8, 1'b0);
    run_op("mul_b",   3'b110, 8'h0F, 8'h0F, 5'd13, 8'hE1, 1'b0, 8, 1'b1);
    run_op("after_busy", 3'b011, 8'hAA, 8'hAA, 5'd14, 8'h00, 1'b1, 0, 1'b0);
    run_op("mul_ff",  3'b110, 8'hFF, 8'hFF, 5'd15, 8'h01, 1'b1, 8, 1'b0);
    run_op("mov0",    3'b111, 8'h55, 8'h00, 5'd16, 8'h00, 1'b1, 0, 1'b0);
    run_op("mov",     3'b111, 8'h00, 8'hA5, 5'd17, 8'hA5, 1'b0, 0, 1'b0);
    run_op("and",     3'b010, 8'h0F, 8'h3C, 5'd31, 8'h0C, 1'b0, 0, 1'b0);

    // Reset in the middle of a MUL's RUN phase
    bus.op    = 3'b110;
    bus.acc   = 8'h10;
    bus.opnd  = 8'h11;
    bus.dst   = 5'd2;
    bus.start = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_wr_en", 32'(bus.wr_en), 32'd0);
    check("arst_dat", 32'(bus.dat_in), 32'd0);
    check("arst_flag", 32'(bus.flag), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_write", wr_count - w0, 0);
    check("arst_idle", 32'(bus.busy), 32'd0);
    run_op("post_rst", 3'b000, 8'h01, 8'hFF, 5'd1, 8'h00, 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Multi-cycle execute stage between the register file's read ports and its write port. It captures the operand and accumulator values at `start`, runs the selected operation over one or more clock cycles, then presents a single write-back beat. That beat carries the result, the destination address and the status flag, which drive the register file's `dat_in`, `wr_addr`, `wr_en` and `flag` inputs.

## Interface
- `AW`, 5, write-address width; matches the register-file `wr_addr` width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation code, captured at accept.
- `opnd`  in  8  operand (register-file `dat_out`), captured at accept.
- `acc`  in  8  accumulator (register-file `dat_acc_out`), captured at accept.
- `dst`  in  AW  destination address, captured at accept.
- `busy`  out  1  high whenever state is not IDLE.
- `wr_en`  out  1  one-cycle write-back strobe.
- `wr_addr`  out  AW  captured `dst`; valid while `wr_en` is high.
- `dat_in`  out  8  result; valid while `wr_en` is high.
- `flag`  out  1  status bit; valid while `wr_en` is high.

## Operation
- FSM states: IDLE, RUN, WB. Reset forces IDLE, and all outputs and internal registers go to 0.
- IDLE, `start`=1:
  - Latch `op`, `opnd`, `acc` and `dst`.
  - Single-cycle ops go to WB.
  - SHL/SHR with count 0 go to WB.
  - All other multi-cycle ops go to RUN.
- RUN: one iteration per cycle. After the last iteration, go to WB.
- WB: `wr_en`=1 with `dat_in`, `flag` and `wr_addr` held stable. Next state is IDLE.
- `start` in RUN or WB is ignored: no queueing, no error.
- Op codes (A = latched acc, B = latched opnd):
  - 000 ADD: result = A+B mod 256; flag = carry out of bit 7.
  - 001 SUB: result = A−B mod 256; flag = 1 when A<B unsigned (borrow).
  - 010 AND: result = A&B; flag = (result==0).
  - 011 XOR: result = A^B; flag = (result==0).
  - 100 SHL: shift A left by B[2:0], one bit per RUN cycle, 0 fill. flag = last bit shifted out; flag = 0 when count is 0.
  - 101 SHR: logical shift right, same rules as SHL.
  - 110 MUL: 8×8 unsigned shift-add, exactly 8 RUN cycles. result = low byte of the product; flag = (high byte != 0).
  - 111 MOV: result = B; flag = (B==0).
- Arithmetic is unsigned 8-bit. The MUL partial product is 16 bits wide internally. B[7:3] is ignored for shifts.
- `wr_en` never asserts outside WB. Exactly one write occurs per accepted request.

## Timing
- Edge numbering: request accepted at edge 0.
  - Single-cycle ops: WB occupies the cycle after edge 0; `wr_en` falls at edge 1.
  - Shift by k (k = 1..7): RUN spans k cycles, WB follows; `wr_en` is high between edges k and k+1.
  - MUL: `wr_en` is high between edges 8 and 9.
- `busy` rises right after edge 0 and falls at the edge that leaves WB.
- The earliest next acceptance is the edge that leaves WB plus one. Back-to-back single-cycle ops therefore run at one per 2 cycles.
- Inputs may change freely after the accept edge; the result depends only on the latched values.
- Reset asserted mid-RUN or mid-WB:
  - Outputs drop to 0 immediately (asynchronous).
  - The operation is discarded and no write occurs.
  - After `rst_n` deasserts, the first `start` is accepted at the first rising edge.

## Test plan
- Reset: assert `rst_n`=0 during a MUL in RUN. Required: `busy`=`wr_en`=`dat_in`=`flag`=0 immediately. After release, no `wr_en` appears without a new `start`.
- ADD/SUB: acc=0xF0, opnd=0x20, ADD, dst=3. Required: one `wr_en` cycle with 0x10, flag=1, wr_addr=3. Then SUB with acc=0x05, opnd=0x07 → 0xFE, flag=1.
- Shifts:
  - SHL with acc=0x81, opnd=0x03 → `wr_en` 3 cycles after accept; result 0x08, flag=0.
  - SHR with acc=0x81, opnd=0x01 → 0x40, flag=1.
  - SHL with count 0 (opnd=0x08) → 0x81, flag=0, latency 1.
- MUL: acc=0x10, opnd=0x11 → 0x10, flag=1, `wr_en` high between edges 8 and 9. acc=0x0F, opnd=0x0F → 0xE1, flag=0.
- Busy rejection: pulse `start` with a different op/dst every cycle during a MUL. Required: exactly one write, carrying the MUL result. The next `start` is accepted only once IDLE is reached.
- Logic/MOV: acc=0xAA, opnd=0xAA, XOR → 0x00, flag=1. MOV with opnd=0x00 → 0x00, flag=1. AND with acc=0x0F, opnd=0x3C → 0x0C, flag=0.
